// File: rtl/mdu_iter_unit_pkg.sv
// Shared MIPS funct codes for the multiply/divide unit and a decode helper.
package mdu_iter_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_unit_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            op_div,
  input  logic [XLEN-1:0] hi_cur,
  input  logic [XLEN-1:0] lo_cur,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Remainder stays below the divisor, so the shifted value is under twice the
  // divisor and the top bit of the XLEN+1 difference is a clean borrow.
  always_comb begin
    sum    = {1'b0, hi_cur} + {1'b0, opnd};
    rem_sh = {hi_cur, lo_cur[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd};
    hi_nxt = hi_cur;
    lo_nxt = lo_cur;
    if (!op_div) begin
      if (lo_cur[0]) {hi_nxt, lo_nxt} = {sum, lo_cur[XLEN-1:1]};
      else           {hi_nxt, lo_nxt} = {1'b0, hi_cur, lo_cur[XLEN-1:1]};
    end else if (diff[XLEN]) begin
      hi_nxt = rem_sh[XLEN-1:0];
      lo_nxt = {lo_cur[XLEN-2:0], 1'b0};
    end else begin
      hi_nxt = diff[XLEN-1:0];
      lo_nxt = {lo_cur[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; 33-cycle mult/div, 1-edge MTHI/MTLO.
// Busy is high while an operation is in flight; Start during Busy is dropped.
module mdu_iter_unit
  import mdu_iter_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [5:0]      Funct,
  input  logic [XLEN-1:0] Rdata1,
  input  logic [XLEN-1:0] Rdata2,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi_w, lo_w, opnd;
  logic            op_div, neg_q, neg_r, div0;

  logic            f_signed, f_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi_nxt, lo_nxt, q_fix, r_fix;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    f_signed = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
    f_div    = (Funct == FUNCT_DIV)  || (Funct == FUNCT_DIVU);
    a_neg    = f_signed & Rdata1[XLEN-1];
    b_neg    = f_signed & Rdata2[XLEN-1];
    a_mag    = a_neg ? -Rdata1 : Rdata1;
    b_mag    = b_neg ? -Rdata2 : Rdata2;
    prod_fix = neg_q ? -{hi_w, lo_w} : {hi_w, lo_w};
    q_fix    = neg_q ? -lo_w : lo_w;
    r_fix    = neg_r ? -hi_w : hi_w;
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .op_div (op_div),
    .hi_cur (hi_w),
    .lo_cur (lo_w),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_w   <= '0;
      lo_w   <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      Busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          if (is_muldiv(Funct)) begin
            // Multiply keeps the multiplier in lo_w; divide shifts the dividend out of it.
            hi_w   <= '0;
            lo_w   <= f_div ? a_mag : b_mag;
            opnd   <= f_div ? b_mag : a_mag;
            op_div <= f_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= f_div && (Rdata2 == '0);
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= S_RUN;
          end else if (Funct == FUNCT_MTHI) begin
            HI <= Rdata1;
          end else if (Funct == FUNCT_MTLO) begin
            LO <= Rdata1;
          end
        end
        S_RUN: begin
          hi_w <= hi_nxt;
          lo_w <= lo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_div) begin
            // A zero divisor leaves the dividend in the remainder; only LO is forced.
            HI <= r_fix;
            LO <= div0 ? '1 : q_fix;
          end else begin
            HI <= prod_fix[2*XLEN-1:XLEN];
            LO <= prod_fix[XLEN-1:0];
          end
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Result = '0;
    if (Funct == FUNCT_MFHI)      Result = HI;
    else if (Funct == FUNCT_MFLO) Result = LO;
  end

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Directed self-checking bench for mdu_iter_unit with hand-computed results.
module tb_mdu_iter_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  Funct = 6'h00;
  logic [31:0] Rdata1 = '0;
  logic [31:0] Rdata2 = '0;
  logic        Busy;
  logic [31:0] HI, LO, Result;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  mdu_iter_unit #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Start  (Start),
    .Funct  (Funct),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .Result (Result)
  );

  always #5 CLK = ~CLK;

  // Presents one request for a single edge; returns 1 ns after that edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    @(posedge CLK);
    #1;
    Start = 1'b0; Funct = 6'h00; Rdata1 = '0; Rdata2 = '0;
  endtask

  // Counts edges after the issue edge until Busy drops, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    issue(f, a, b);
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, Busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 33) begin
      errors++; $display("FAIL %s latency: got %0d want 33", name, cyc);
    end
    checks++;
    if (HI !== exp_hi) begin
      errors++; $display("FAIL %s HI: got %h want %h", name, HI, exp_hi);
    end
    checks++;
    if (LO !== exp_lo) begin
      errors++; $display("FAIL %s LO: got %h want %h", name, LO, exp_lo);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    Funct = F_MFHI;
    #1;
    checks++;
    if (Result !== 32'h0) begin errors++; $display("FAIL reset mfhi: got %h want 0", Result); end
    Funct = F_MFLO;
    #1;
    checks++;
    if (Result !== 32'h0) begin errors++; $display("FAIL reset mflo: got %h want 0", Result); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", Busy); end
    checks++;
    if (HI !== 32'h0 || LO !== 32'h0) begin
      errors++; $display("FAIL reset hilo: got %h/%h want 0/0", HI, LO);
    end
    Funct = 6'h00;
  endtask

  task automatic test_muldiv;
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu",      F_DIVU,  32'd86332,    32'd17,       32'h00000006, 32'h000013D6);
    run_op("div_neg",   F_DIV,   32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD);
    run_op("div_zero",  F_DIV,   32'd23,       32'd0,        32'h00000017, 32'hFFFFFFFF);
    run_op("divu_zero", F_DIVU,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("mult_both_neg", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
  endtask

  task automatic test_move;
    issue(F_MTHI, 32'hCAFEF00D, 32'h0);
    checks++;
    if (HI !== 32'hCAFEF00D || Busy !== 1'b0) begin
      errors++; $display("FAIL mthi: got %h busy %b want cafef00d busy 0", HI, Busy);
    end
    issue(F_MTLO, 32'h0BADBEEF, 32'h0);
    Funct = F_MFLO;
    #1;
    checks++;
    if (Result !== 32'h0BADBEEF) begin
      errors++; $display("FAIL mflo_result: got %h want 0badbeef", Result);
    end
    Funct = F_MFHI;
    #1;
    checks++;
    if (Result !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mfhi_result: got %h want cafef00d", Result);
    end
    Funct = 6'h00;
    issue(6'h20, 32'h11111111, 32'h2);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'hCAFEF00D || LO !== 32'h0BADBEEF) begin
      errors++; $display("FAIL bad_funct: got busy %b hi %h lo %h", Busy, HI, LO);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    issue(F_MTHI, 32'h12345678, 32'h0);
    checks++;
    if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi2: got %h want 12345678", HI); end
    issue(F_MULT, 32'd6, 32'hFFFFFFF9);
    cyc = 0;
    repeat (4) begin @(posedge CLK); #1; cyc++; end
    @(negedge CLK);
    Start = 1'b1; Funct = F_MTLO; Rdata1 = 32'hAAAAAAAA;
    @(posedge CLK);
    #1;
    cyc++;
    Start = 1'b0; Funct = 6'h00; Rdata1 = '0;
    checks++;
    if (Busy !== 1'b1 || LO !== 32'h0BADBEEF) begin
      errors++; $display("FAIL mtlo_while_busy: got busy %b lo %h want 1/0badbeef", Busy, LO);
    end
    while (Busy === 1'b1 && cyc < 100) begin @(posedge CLK); #1; cyc++; end
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL busy_latency: got %0d want 33", cyc); end
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFD6) begin
      errors++; $display("FAIL busy_mult: got %h/%h want ffffffff/ffffffd6", HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    issue(F_MULTU, 32'd5, 32'd5);
    checks++;
    if (Busy !== 1'b1 || HI !== 32'd2 || LO !== 32'd14) begin
      errors++; $display("FAIL b2b_first: got busy %b %h/%h want 1 2/e", Busy, HI, LO);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || HI !== 32'd0 || LO !== 32'd25) begin
      errors++; $display("FAIL b2b_second: got %0d %h/%h want 33 0/19", cyc, HI, LO);
    end
  endtask

  task automatic test_reset_mid_op;
    issue(F_DIV, 32'd1000, 32'd7);
    repeat (9) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++; $display("FAIL reset_mid_div: got busy %b %h/%h want 0 0/0", Busy, HI, LO);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++; $display("FAIL after_abort: got busy %b %h/%h want 0 0/0", Busy, HI, LO);
    end
  endtask

  initial begin
    test_reset;
    test_muldiv;
    test_move;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
